// File: rtl/vga_timing_pkg.sv
// Geometry presets and helpers shared by the VGA timing generator.
package vga_timing_pkg;

  function automatic int axis_total(input int sync_len, input int back_len,
                                    input int act_len, input int front_len);
    return sync_len + back_len + act_len + front_len;
  endfunction

  // 640x480 @ 60 Hz
  localparam int VGA640_H_SYNC  = 96;
  localparam int VGA640_H_BACK  = 48;
  localparam int VGA640_H_ACT   = 640;
  localparam int VGA640_H_FRONT = 16;
  localparam int VGA640_V_SYNC  = 2;
  localparam int VGA640_V_BACK  = 33;
  localparam int VGA640_V_ACT   = 480;
  localparam int VGA640_V_FRONT = 10;
  localparam int VGA640_H_TOTAL = axis_total(VGA640_H_SYNC, VGA640_H_BACK,
                                             VGA640_H_ACT, VGA640_H_FRONT);
  localparam int VGA640_V_TOTAL = axis_total(VGA640_V_SYNC, VGA640_V_BACK,
                                             VGA640_V_ACT, VGA640_V_FRONT);

  // 800x600 @ 72 Hz
  localparam int SVGA800_H_SYNC  = 120;
  localparam int SVGA800_H_BACK  = 64;
  localparam int SVGA800_H_ACT   = 800;
  localparam int SVGA800_H_FRONT = 56;
  localparam int SVGA800_V_SYNC  = 6;
  localparam int SVGA800_V_BACK  = 23;
  localparam int SVGA800_V_ACT   = 600;
  localparam int SVGA800_V_FRONT = 37;
  localparam int SVGA800_H_TOTAL = axis_total(SVGA800_H_SYNC, SVGA800_H_BACK,
                                              SVGA800_H_ACT, SVGA800_H_FRONT);
  localparam int SVGA800_V_TOTAL = axis_total(SVGA800_V_SYNC, SVGA800_V_BACK,
                                              SVGA800_V_ACT, SVGA800_V_FRONT);

  localparam int REQ_LEAD_DEFAULT = 2;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus sync, active, first-active and
// look-ahead window decode. LEAD shifts the window earlier by LEAD counts.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int SYNC  = 96,
  parameter int BACK  = 48,
  parameter int ACT   = 640,
  parameter int FRONT = 16,
  parameter int LEAD  = 0,
  parameter int CNT_W = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] coord_o,
  output logic             tc_o,
  output logic             sync_o,
  output logic             active_o,
  output logic             first_o,
  output logic             lead_o
);

  localparam int TOTAL = axis_total(SYNC, BACK, ACT, FRONT);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(SYNC);
  localparam logic [CNT_W-1:0] ACT_LO   = CNT_W'(SYNC + BACK);
  localparam logic [CNT_W-1:0] ACT_HI   = CNT_W'(SYNC + BACK + ACT);
  localparam logic [CNT_W-1:0] LEAD_LO  = CNT_W'(SYNC + BACK - LEAD);
  localparam logic [CNT_W-1:0] LEAD_HI  = CNT_W'(SYNC + BACK + ACT - LEAD);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o     = (cnt_q == LAST);
  assign sync_o   = (cnt_q < SYNC_END);
  assign active_o = (cnt_q >= ACT_LO) && (cnt_q < ACT_HI);
  assign first_o  = (cnt_q == ACT_LO);
  assign lead_o   = (cnt_q >= LEAD_LO) && (cnt_q < LEAD_HI);
  assign coord_o  = cnt_q - ACT_LO;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator with pixel-fetch request and registered RGB.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit free-running oFRAME_CNT output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BACK   = VGA640_H_BACK,
  parameter int H_ACT    = VGA640_H_ACT,
  parameter int H_FRONT  = VGA640_H_FRONT,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BACK   = VGA640_V_BACK,
  parameter int V_ACT    = VGA640_V_ACT,
  parameter int V_FRONT  = VGA640_V_FRONT,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 10,
  parameter int CNT_W    = 12,
  parameter int REQ_LEAD = REQ_LEAD_DEFAULT
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  output logic               oRequest,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               oVGA_H_SYNC,
  output logic               oVGA_V_SYNC,
  output logic               oVGA_BLANK_N,
  output logic               oVGA_SYNC,
  output logic               oVGA_CLOCK,
  output logic [CNT_W-1:0]   oVGA_X,
  output logic [CNT_W-1:0]   oVGA_Y,
  output logic               oVGA_ACTIVE,
  output logic               oLINE_START,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic [15:0]        oFRAME_CNT,
`endif
  output logic               oFRAME_START
);

  logic [CNT_W-1:0] h_coord, v_coord;
  logic h_tc, h_sync, h_act, h_first, h_lead;
  logic v_tc_unused, v_sync, v_act, v_first, v_lead;

  // The H window is pulled forward by REQ_LEAD+1 so the request register
  // leads the RGB register by exactly that many cycles.
  vga_axis_counter #(
    .SYNC(H_SYNC), .BACK(H_BACK), .ACT(H_ACT), .FRONT(H_FRONT),
    .LEAD(REQ_LEAD + 1), .CNT_W(CNT_W)
  ) u_h (
    .clk_i(iCLK), .rst_i(iRST), .en_i(1'b1),
    .coord_o(h_coord), .tc_o(h_tc), .sync_o(h_sync),
    .active_o(h_act), .first_o(h_first), .lead_o(h_lead)
  );

  vga_axis_counter #(
    .SYNC(V_SYNC), .BACK(V_BACK), .ACT(V_ACT), .FRONT(V_FRONT),
    .LEAD(0), .CNT_W(CNT_W)
  ) u_v (
    .clk_i(iCLK), .rst_i(iRST), .en_i(h_tc),
    .coord_o(v_coord), .tc_o(v_tc_unused), .sync_o(v_sync),
    .active_o(v_act), .first_o(v_first), .lead_o(v_lead)
  );

  logic               hs_q, vs_q, act_q, ls_q, fs_q, req_q;
  logic               hs_d, vs_d, act_d, ls_d, fs_d, req_d;
  logic [CNT_W-1:0]   x_q, y_q, x_d, y_d;
  logic [COLOR_W-1:0] r_q, g_q, b_q, r_d, g_d, b_d;

  always_comb begin
    act_d = h_act & v_act;
    hs_d  = h_sync ? HS_POL : ~HS_POL;
    vs_d  = v_sync ? VS_POL : ~VS_POL;
    req_d = h_lead & v_lead;
    ls_d  = h_first & v_act;
    fs_d  = h_first & v_first;
    x_d   = act_d ? h_coord : '0;
    y_d   = act_d ? v_coord : '0;
    // Requests map 1:1 onto active pixels, so gating on active also zeroes
    // any pixel that had no request behind it.
    r_d   = act_d ? iRed   : '0;
    g_d   = act_d ? iGreen : '0;
    b_d   = act_d ? iBlue  : '0;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      act_q <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
      req_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
    end else begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      act_q <= act_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
      req_q <= req_d;
      x_q   <= x_d;
      y_q   <= y_d;
      r_q   <= r_d;
      g_q   <= g_d;
      b_q   <= b_d;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fs_d ? fcnt_q + 16'd1 : fcnt_q;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) fcnt_q <= '0;
    else      fcnt_q <= fcnt_d;
  end

  assign oFRAME_CNT = fcnt_q;
`endif

  assign oRequest     = req_q;
  assign oVGA_R       = r_q;
  assign oVGA_G       = g_q;
  assign oVGA_B       = b_q;
  assign oVGA_H_SYNC  = hs_q;
  assign oVGA_V_SYNC  = vs_q;
  assign oVGA_BLANK_N = act_q;
  assign oVGA_ACTIVE  = act_q;
  assign oVGA_X       = x_q;
  assign oVGA_Y       = y_q;
  assign oLINE_START  = ls_q;
  assign oFRAME_START = fs_q;
  assign oVGA_SYNC    = 1'b0;
  assign oVGA_CLOCK   = iCLK;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small geometries checked cycle-for-cycle
// against a pixel-index reference model with a random-data pixel source.
module tb_vga_timing_gen;

  localparam int CW = 8;
  localparam int NW = 8;
  // DUT 0: small geometry, high-true syncs, lead 1
  localparam int A_HS = 2, A_HB = 2, A_HA = 4, A_HF = 2;
  localparam int A_VS = 1, A_VB = 1, A_VA = 3, A_VF = 1, A_L = 1;
  // DUT 1: mixed polarity, longer lead
  localparam int B_HS = 3, B_HB = 4, B_HA = 8, B_HF = 3;
  localparam int B_VS = 2, B_VB = 2, B_VA = 5, B_VF = 1, B_L = 3;

  int g_hs[2] = '{A_HS, B_HS};
  int g_hb[2] = '{A_HB, B_HB};
  int g_ha[2] = '{A_HA, B_HA};
  int g_hf[2] = '{A_HF, B_HF};
  int g_vs[2] = '{A_VS, B_VS};
  int g_vb[2] = '{A_VB, B_VB};
  int g_va[2] = '{A_VA, B_VA};
  int g_vf[2] = '{A_VF, B_VF};
  int g_l[2]  = '{A_L, B_L};
  bit g_hp[2] = '{1'b1, 1'b0};
  bit g_vp[2] = '{1'b1, 1'b1};

  typedef struct packed {
    bit hs, vs, blank, act, ls, fs, req;
    int x;
    int y;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [CW-1:0] ir[2], ig[2], ib[2], r[2], g[2], b[2];
  logic          req[2], hs[2], vs[2], blank[2], syn[2], vclk[2];
  logic          act[2], ls[2], fs[2];
  logic [NW-1:0] x[2], y[2];
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]   fcnt[2];
`endif

  int checks = 0;
  int errors = 0;
  int kk = 0;
  logic [48:0] exp_vec[2];
  logic [15:0] fexp[2];
  bit          pv[2][4];
  logic [7:0]  pr[2][4], pg[2][4], pb[2][4];
  int          rcnt[2];
  logic [15:0] sbq[2][$];

  vga_timing_gen #(
    .H_SYNC(A_HS), .H_BACK(A_HB), .H_ACT(A_HA), .H_FRONT(A_HF),
    .V_SYNC(A_VS), .V_BACK(A_VB), .V_ACT(A_VA), .V_FRONT(A_VF),
    .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(CW), .CNT_W(NW), .REQ_LEAD(A_L)
  ) u_dut_a (
    .iCLK(clk), .iRST(rst), .iRed(ir[0]), .iGreen(ig[0]), .iBlue(ib[0]),
    .oRequest(req[0]), .oVGA_R(r[0]), .oVGA_G(g[0]), .oVGA_B(b[0]),
    .oVGA_H_SYNC(hs[0]), .oVGA_V_SYNC(vs[0]), .oVGA_BLANK_N(blank[0]),
    .oVGA_SYNC(syn[0]), .oVGA_CLOCK(vclk[0]), .oVGA_X(x[0]), .oVGA_Y(y[0]),
    .oVGA_ACTIVE(act[0]), .oLINE_START(ls[0]),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .oFRAME_CNT(fcnt[0]),
`endif
    .oFRAME_START(fs[0])
  );

  vga_timing_gen #(
    .H_SYNC(B_HS), .H_BACK(B_HB), .H_ACT(B_HA), .H_FRONT(B_HF),
    .V_SYNC(B_VS), .V_BACK(B_VB), .V_ACT(B_VA), .V_FRONT(B_VF),
    .HS_POL(1'b0), .VS_POL(1'b1), .COLOR_W(CW), .CNT_W(NW), .REQ_LEAD(B_L)
  ) u_dut_b (
    .iCLK(clk), .iRST(rst), .iRed(ir[1]), .iGreen(ig[1]), .iBlue(ib[1]),
    .oRequest(req[1]), .oVGA_R(r[1]), .oVGA_G(g[1]), .oVGA_B(b[1]),
    .oVGA_H_SYNC(hs[1]), .oVGA_V_SYNC(vs[1]), .oVGA_BLANK_N(blank[1]),
    .oVGA_SYNC(syn[1]), .oVGA_CLOCK(vclk[1]), .oVGA_X(x[1]), .oVGA_Y(y[1]),
    .oVGA_ACTIVE(act[1]), .oLINE_START(ls[1]),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .oFRAME_CNT(fcnt[1]),
`endif
    .oFRAME_START(fs[1])
  );

  function automatic int htot(int d);
    return g_hs[d] + g_hb[d] + g_ha[d] + g_hf[d];
  endfunction

  function automatic int vtot(int d);
    return g_vs[d] + g_vb[d] + g_va[d] + g_vf[d];
  endfunction

  // p is a pixel index counted from the frame origin (hc=vc=0)
  function automatic bit pix_act(int d, int p);
    int q, h, v;
    q = p % (htot(d) * vtot(d));
    h = q % htot(d);
    v = q / htot(d);
    return (h >= g_hs[d] + g_hb[d]) && (h < g_hs[d] + g_hb[d] + g_ha[d]) &&
           (v >= g_vs[d] + g_vb[d]) && (v < g_vs[d] + g_vb[d] + g_va[d]);
  endfunction

  // n = non-reset edges since the last reset edge; edge n shows pixel n-1
  function automatic exp_t model(int d, int n);
    exp_t e;
    int p, h, v;
    e = '0;
    e.hs = !g_hp[d];
    e.vs = !g_vp[d];
    if (n == 0) return e;
    p = (n - 1) % (htot(d) * vtot(d));
    h = p % htot(d);
    v = p / htot(d);
    e.hs    = (h < g_hs[d]) ? g_hp[d] : !g_hp[d];
    e.vs    = (v < g_vs[d]) ? g_vp[d] : !g_vp[d];
    e.act   = pix_act(d, p);
    e.blank = e.act;
    if (e.act) begin
      e.x = h - (g_hs[d] + g_hb[d]);
      e.y = v - (g_vs[d] + g_vb[d]);
    end
    e.ls  = e.act && (h == g_hs[d] + g_hb[d]);
    e.fs  = e.ls && (v == g_vs[d] + g_vb[d]);
    e.req = pix_act(d, p + g_l[d] + 1);
    return e;
  endfunction

  // One clock: drive reset, update expectations, run the pixel source.
  task automatic advance(input bit rst_v);
    exp_t e;
    logic [7:0] er, eg, eb;
    logic [15:0] gb;
    rst = rst_v;
    @(posedge clk);
    #1;
    if (rst_v) kk = 0;
    else       kk++;
    for (int d = 0; d < 2; d++) begin
      e = model(d, kk);
      if (rst_v) begin
        sbq[d].delete();
        rcnt[d] = 0;
        fexp[d] = 16'd0;
        for (int i = 0; i < 4; i++) pv[d][i] = 1'b0;
      end
      er = 8'd0; eg = 8'd0; eb = 8'd0;
      if (e.act) begin
        er = 8'(e.x);
        if (sbq[d].size() > 0) begin
          gb = sbq[d].pop_front();
          eg = gb[15:8];
          eb = gb[7:0];
        end else begin
          eg = 'x;
          eb = 'x;
        end
      end
      if (e.fs) fexp[d] = fexp[d] + 16'd1;
      exp_vec[d] = {e.hs, e.vs, e.blank, e.act, e.ls, e.fs, e.req, 1'b0, 1'b1,
                    8'(e.x), 8'(e.y), er, eg, eb};
      for (int i = 3; i > 0; i--) begin
        pv[d][i] = pv[d][i-1];
        pr[d][i] = pr[d][i-1];
        pg[d][i] = pg[d][i-1];
        pb[d][i] = pb[d][i-1];
      end
      pv[d][0] = (req[d] === 1'b1);
      if (pv[d][0]) begin
        pr[d][0] = 8'(rcnt[d]);
        rcnt[d]  = (rcnt[d] + 1) % g_ha[d];
        pg[d][0] = 8'($urandom);
        pb[d][0] = 8'($urandom);
        sbq[d].push_back({pg[d][0], pb[d][0]});
      end
      if (pv[d][g_l[d]]) begin
        ir[d] = pr[d][g_l[d]];
        ig[d] = pg[d][g_l[d]];
        ib[d] = pb[d][g_l[d]];
      end else begin
        ir[d] = 8'($urandom);
        ig[d] = 8'($urandom);
        ib[d] = 8'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    logic [48:0] obs;
    for (int c = 0; c < 4; c++) begin
      advance(1'b1);
      for (int d = 0; d < 2; d++) begin
        obs = {hs[d], vs[d], blank[d], act[d], ls[d], fs[d], req[d], syn[d], vclk[d],
               x[d], y[d], r[d], g[d], b[d]};
        checks++;
        if (obs !== exp_vec[d]) begin
          errors++;
          $display("FAIL reset dut%0d cycle=%0d got=%h want=%h", d, c, obs, exp_vec[d]);
        end
      end
    end
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (vclk[d] !== 1'b0) begin
        errors++;
        $display("FAIL vga_clock_low dut%0d got=%b want=0", d, vclk[d]);
      end
    end
  endtask

  task automatic test_frame();
    logic [48:0] obs;
    int nreq[2], nls[2], nfs[2];
    for (int d = 0; d < 2; d++) begin
      nreq[d] = 0; nls[d] = 0; nfs[d] = 0;
    end
    for (int c = 0; c < 2 * htot(1) * vtot(1); c++) begin
      advance(1'b0);
      for (int d = 0; d < 2; d++) begin
        obs = {hs[d], vs[d], blank[d], act[d], ls[d], fs[d], req[d], syn[d], vclk[d],
               x[d], y[d], r[d], g[d], b[d]};
        checks++;
        if (obs !== exp_vec[d]) begin
          errors++;
          $display("FAIL frame dut%0d k=%0d got=%h want=%h", d, kk, obs, exp_vec[d]);
        end
        if (kk <= htot(d) * vtot(d)) begin
          nreq[d] += (req[d] === 1'b1) ? 1 : 0;
          nls[d]  += (ls[d] === 1'b1) ? 1 : 0;
          nfs[d]  += (fs[d] === 1'b1) ? 1 : 0;
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      checks += 3;
      if (nreq[d] !== g_ha[d] * g_va[d]) begin
        errors++;
        $display("FAIL req_per_frame dut%0d got=%0d want=%0d", d, nreq[d], g_ha[d] * g_va[d]);
      end
      if (nls[d] !== g_va[d]) begin
        errors++;
        $display("FAIL line_starts dut%0d got=%0d want=%0d", d, nls[d], g_va[d]);
      end
      if (nfs[d] !== 1) begin
        errors++;
        $display("FAIL frame_starts dut%0d got=%0d want=1", d, nfs[d]);
      end
    end
  endtask

  task automatic test_random_reset();
    logic [48:0] obs;
    int run_len, rst_len;
    for (int it = 0; it < 8; it++) begin
      run_len = $urandom_range(1, 200);
      rst_len = $urandom_range(1, 3);
      for (int c = 0; c < run_len + rst_len; c++) begin
        advance(c >= run_len);
        for (int d = 0; d < 2; d++) begin
          obs = {hs[d], vs[d], blank[d], act[d], ls[d], fs[d], req[d], syn[d], vclk[d],
                 x[d], y[d], r[d], g[d], b[d]};
          checks++;
          if (obs !== exp_vec[d]) begin
            errors++;
            $display("FAIL midreset it=%0d dut%0d k=%0d got=%h want=%h",
                     it, d, kk, obs, exp_vec[d]);
          end
        end
      end
    end
    for (int c = 0; c < 150; c++) begin
      advance(1'b0);
      for (int d = 0; d < 2; d++) begin
        obs = {hs[d], vs[d], blank[d], act[d], ls[d], fs[d], req[d], syn[d], vclk[d],
               x[d], y[d], r[d], g[d], b[d]};
        checks++;
        if (obs !== exp_vec[d]) begin
          errors++;
          $display("FAIL restart dut%0d k=%0d got=%h want=%h", d, kk, obs, exp_vec[d]);
        end
      end
    end
  endtask

`ifdef VGA_TIMING_FRAME_CNT_EN
  task automatic test_frame_cnt();
    advance(1'b1);
    for (int c = 0; c < 3 * htot(1) * vtot(1); c++) advance(1'b0);
    checks += 3;
    if (fcnt[1] !== 16'd3) begin
      errors++;
      $display("FAIL frame_cnt_3 dut1 got=%0d want=3", fcnt[1]);
    end
    if (fcnt[0] !== fexp[0]) begin
      errors++;
      $display("FAIL frame_cnt dut0 got=%0d want=%0d", fcnt[0], fexp[0]);
    end
    if (fexp[0] !== 16'd9) begin
      errors++;
      $display("FAIL frame_cnt_model dut0 got=%0d want=9", fexp[0]);
    end
    advance(1'b1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (fcnt[d] !== 16'd0) begin
        errors++;
        $display("FAIL frame_cnt_clear dut%0d got=%0d want=0", d, fcnt[d]);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      ir[d] = '0; ig[d] = '0; ib[d] = '0;
      rcnt[d] = 0;
      fexp[d] = 16'd0;
      for (int i = 0; i < 4; i++) begin
        pv[d][i] = 1'b0; pr[d][i] = '0; pg[d][i] = '0; pb[d][i] = '0;
      end
    end
    test_reset();
    test_frame();
    test_random_reset();
`ifdef VGA_TIMING_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
